phv_egress_buffer: RTL and testbench

PHV_EGRESS_BUFFER -- requirements
Module: phv_egress_buffer

---
 rtl/rmt_pkg.sv | 15 +
 rtl/phv_egress_buffer.sv | 86 ++++++++
 tb/tb_phv_egress_buffer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rmt_pkg.sv
// Shared match-action pipeline definitions: PHV container geometry and PHV type.
package rmt_pkg;

  localparam int CONT_2B_W     = 16;
  localparam int CONT_4B_W     = 32;
  localparam int CONT_6B_W     = 48;
  localparam int CONT_PER_TYPE = 8;
  localparam int META_W        = 356;

  // 8x6B + 8x4B + 8x2B containers followed by the metadata block.
  localparam int PHV_LEN = CONT_PER_TYPE * (CONT_6B_W + CONT_4B_W + CONT_2B_W) + META_W;

  typedef logic [PHV_LEN-1:0] phv_t;

endpackage

// File: rtl/phv_egress_buffer.sv
// Egress PHV buffer: first-word-fall-through FIFO with registered head output,
// slack-aware ready to a backpressure-blind upstream, and counted drops on overflow.
module phv_egress_buffer #(
  parameter int PHV_LEN = rmt_pkg::PHV_LEN,
  parameter int DEPTH   = 8,
  parameter int SLACK   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PHV_LEN-1:0]       phv_in,
  input  logic                     phv_valid_in,
  output logic                     ready_out,
  output logic [PHV_LEN-1:0]       phv_out,
  output logic                     phv_valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              drop_cnt,
  output logic                     overflow
);

  localparam int              AW          = $clog2(DEPTH);
  localparam logic [AW:0]     FULL        = (AW+1)'(DEPTH);
  localparam logic [AW:0]     READY_LIMIT = (AW+1)'(DEPTH - SLACK);

  logic [PHV_LEN-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      rd_ptr_next;
  logic [AW:0]        occ_next;
  logic               push;
  logic               pop;
  logic               drop;

  assign phv_valid_out = (occupancy != '0);
  assign pop           = phv_valid_out & ready_in;
  // A full buffer still accepts a PHV when the head leaves in the same cycle.
  assign push          = phv_valid_in & ((occupancy < FULL) | pop);
  assign drop          = phv_valid_in & ~push;
  assign rd_ptr_next   = rd_ptr + AW'(1);

  always_comb begin
    occ_next = occupancy;
    if (push && !pop)      occ_next = occupancy + (AW+1)'(1);
    else if (pop && !push) occ_next = occupancy - (AW+1)'(1);
  end

  // NOTE: the storage array is deliberately not reset so it maps onto LUT-RAM;
  // validity is carried entirely by the reset pointers and occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= phv_in;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      ready_out <= 1'b0;
      phv_out   <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      occupancy <= occ_next;
      ready_out <= (occ_next < READY_LIMIT);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_next;

      // Head register: next entry from the array, or the incoming PHV when it
      // becomes the head directly; otherwise it keeps its last value.
      if (pop) begin
        if (occupancy > (AW+1)'(1)) phv_out <= mem[rd_ptr_next];
        else if (push)              phv_out <= phv_in;
      end else if (push && occupancy == '0) begin
        phv_out <= phv_in;
      end

      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_phv_egress_buffer.sv
// Directed and random-stall bench for phv_egress_buffer with default parameters.
module tb_phv_egress_buffer;
  import rmt_pkg::*;

  localparam int OW = $clog2(8) + 1;

  logic          clk = 1'b0;
  logic          rst;
  phv_t          phv_in;
  logic          phv_valid_in;
  logic          ready_out;
  phv_t          phv_out;
  logic          phv_valid_out;
  logic          ready_in;
  logic [OW-1:0] occupancy;
  logic [15:0]   drop_cnt;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  phv_egress_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .phv_in        (phv_in),
    .phv_valid_in  (phv_valid_in),
    .ready_out     (ready_out),
    .phv_out       (phv_out),
    .phv_valid_out (phv_valid_out),
    .ready_in      (ready_in),
    .occupancy     (occupancy),
    .drop_cnt      (drop_cnt),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  function automatic phv_t pat(input int i);
    return phv_t'({36{32'(i) ^ 32'hC0DE0000}});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; phv_valid_in = 1'b0; ready_in = 1'b0; phv_in = '0;
    #12;
    n_checks++; if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_checks++; if (phv_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", phv_valid_out); end
    n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready_out); end
    n_checks++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %0d/%b want 0/0", drop_cnt, overflow); end
    n_checks++; if (phv_out !== '0) begin n_fail++; $display("FAIL reset_phv got %h want 0", phv_out); end
    rst = 1'b0;
    tick();
    n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", ready_out); end
  endtask

  task automatic test_single_pass();
    phv_t a5;
    a5 = phv_t'({141{8'hA5}});
    ready_in = 1'b1; phv_valid_in = 1'b1; phv_in = a5;
    tick();
    phv_valid_in = 1'b0; phv_in = '0;
    n_checks++; if (phv_valid_out !== 1'b1 || phv_out !== a5) begin n_fail++; $display("FAIL single_out got v=%b %h want v=1 %h", phv_valid_out, phv_out, a5); end
    n_checks++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL single_occ1 got %0d want 1", occupancy); end
    tick();
    n_checks++; if (occupancy !== 4'd0 || phv_valid_out !== 1'b0) begin n_fail++; $display("FAIL single_drain got occ=%0d v=%b want 0/0", occupancy, phv_valid_out); end
    n_checks++; if (phv_out !== a5) begin n_fail++; $display("FAIL single_hold got %h want %h", phv_out, a5); end
    // ready_in on an empty buffer must not underflow it.
    tick();
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL empty_ready_in got %0d want 0", occupancy); end
  endtask

  task automatic test_backpressure();
    ready_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      phv_valid_in = 1'b1; phv_in = pat(i);
      tick();
      n_checks++; if (occupancy !== 4'(i + 1)) begin n_fail++; $display("FAIL bp_occ[%0d] got %0d want %0d", i, occupancy, i + 1); end
      n_checks++; if (ready_out !== (i < 4)) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want %b", i, ready_out, i < 4); end
    end
    phv_valid_in = 1'b0;
    n_checks++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL bp_nodrop got %0d/%b want 0/0", drop_cnt, overflow); end
    n_checks++; if (phv_out !== pat(0)) begin n_fail++; $display("FAIL bp_head got %h want %h", phv_out, pat(0)); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      phv_valid_in = 1'b1; phv_in = pat(100 + i);
      tick();
      n_checks++; if (drop_cnt !== 16'(i + 1) || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_cnt[%0d] got %0d/%b want %0d/1", i, drop_cnt, overflow, i + 1); end
      n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL ovf_occ[%0d] got %0d want 8", i, occupancy); end
    end
    phv_valid_in = 1'b0; ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (phv_valid_out !== 1'b1 || phv_out !== pat(i)) begin n_fail++; $display("FAIL ovf_drain[%0d] got v=%b %h want %h", i, phv_valid_out, phv_out, pat(i)); end
      tick();
    end
    n_checks++; if (occupancy !== 4'd0 || ready_out !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got occ=%0d rdy=%b want 0/1", occupancy, ready_out); end
    n_checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_sticky got %b/%0d want 1/2", overflow, drop_cnt); end
  endtask

  task automatic test_full_push_pop();
    ready_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      phv_valid_in = 1'b1; phv_in = pat(200 + i);
      tick();
    end
    ready_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      phv_in = pat(208 + k);
      n_checks++; if (phv_out !== pat(200 + k)) begin n_fail++; $display("FAIL full_head[%0d] got %h want %h", k, phv_out, pat(200 + k)); end
      tick();
      n_checks++; if (occupancy !== 4'd8 || drop_cnt !== 16'd2) begin n_fail++; $display("FAIL full_occ[%0d] got %0d/%0d want 8/2", k, occupancy, drop_cnt); end
    end
    phv_valid_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (phv_out !== pat(220 + i)) begin n_fail++; $display("FAIL full_drain[%0d] got %h want %h", i, phv_out, pat(220 + i)); end
      tick();
    end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL full_empty got %0d want 0", occupancy); end
  endtask

  task automatic test_one_entry_stream();
    ready_in = 1'b1; phv_valid_in = 1'b1; phv_in = pat(300);
    tick();
    for (int k = 1; k <= 4; k++) begin
      phv_in = pat(300 + k);
      tick();
      n_checks++; if (occupancy !== 4'd1 || phv_out !== pat(300 + k)) begin n_fail++; $display("FAIL one_stream[%0d] got occ=%0d %h want 1 %h", k, occupancy, phv_out, pat(300 + k)); end
    end
    phv_valid_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    ready_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      phv_valid_in = 1'b1; phv_in = pat(400 + i);
      tick();
    end
    phv_valid_in = 1'b0;
    n_checks++; if (occupancy !== 4'd6) begin n_fail++; $display("FAIL mid_pre_occ got %0d want 6", occupancy); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (phv_valid_out !== 1'b0 || occupancy !== 4'd0) begin n_fail++; $display("FAIL mid_async got v=%b occ=%0d want 0/0", phv_valid_out, occupancy); end
    n_checks++; if (ready_out !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0 || phv_out !== '0) begin n_fail++; $display("FAIL mid_async_regs got rdy=%b ovf=%b cnt=%0d", ready_out, overflow, drop_cnt); end
    #1 rst = 1'b0;
    tick();
    n_checks++; if (ready_out !== 1'b1 || occupancy !== 4'd0) begin n_fail++; $display("FAIL mid_release got rdy=%b occ=%0d want 1/0", ready_out, occupancy); end
  endtask

  task automatic test_random_stall();
    phv_t q[$];
    phv_t prev_out;
    logic prev_stall;
    int   drops;
    logic m_push, m_pop;
    drops = 0; prev_stall = 1'b0; prev_out = '0;
    for (int n = 0; n < 10000; n++) begin
      phv_valid_in = ($urandom_range(0, 9) < 6);
      ready_in     = ($urandom_range(0, 1) == 1);
      phv_in       = pat(1000 + n);
      n_checks++; if (phv_valid_out !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", n, phv_valid_out, q.size() > 0); end
      if (q.size() > 0) begin
        n_checks++; if (phv_out !== q[0]) begin n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", n, phv_out, q[0]); end
      end
      if (prev_stall) begin
        n_checks++; if (phv_out !== prev_out) begin n_fail++; $display("FAIL rnd_stable[%0d] got %h want %h", n, phv_out, prev_out); end
      end
      m_pop  = (q.size() > 0) && ready_in;
      m_push = phv_valid_in && ((q.size() < 8) || m_pop);
      prev_stall = (q.size() > 0) && !ready_in;
      prev_out   = phv_out;
      tick();
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(phv_in);
      else if (phv_valid_in && drops < 65535) drops++;
      n_checks++; if (ready_out !== (q.size() < 5)) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b want %b", n, ready_out, q.size() < 5); end
    end
    phv_valid_in = 1'b0;
    n_checks++; if (drop_cnt !== 16'(drops)) begin n_fail++; $display("FAIL rnd_drops got %0d want %0d", drop_cnt, drops); end
    n_checks++; if (occupancy !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_occ got %0d want %0d", occupancy, q.size()); end
    n_checks++; if (overflow !== (drops > 0)) begin n_fail++; $display("FAIL rnd_overflow got %b want %b", overflow, drops > 0); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_one_entry_stream();
    test_reset_mid();
    test_random_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
